alu_exec_stage: RTL and testbench

- Execute stage directly downstream of the ALU control decoder.
- Consumes the decoder's 4-bit ALU operation code plus operands and performs the ALU operation.
- Registers the result, zero flag, branch decision and write-back control into the EX/MEM boundary.
- Uses a valid/ready handshake with a 2-entry skid buffer, so a memory-stage stall never drops or duplicates an instruction.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_exec_stage_alu_core.sv | 32 +++
 rtl/alu_exec_stage.sv | 121 ++++++++++++
 tb/tb_alu_exec_stage.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes and the EX/MEM boundary bundle.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  localparam int ALU_XLEN       = 32;
  localparam int ALU_REG_ADDR_W = 5;

  // The bundle widths follow the package defaults; the stage parameters default to them.
  typedef struct packed {
    logic [ALU_XLEN-1:0]       alu_result;
    logic                      zero;
    logic                      branch_taken;
    logic [ALU_XLEN-1:0]       branch_target;
    logic [ALU_XLEN-1:0]       store_data;
    logic [ALU_REG_ADDR_W-1:0] rd;
    logic                      reg_write;
    logic                      mem_read;
    logic                      mem_write;
  } ex_mem_t;

endpackage

// File: rtl/alu_exec_stage_alu_core.sv
// Combinational ALU: wrapping add/sub plus bitwise and/or/xor; unknown codes add.
module alu_core
  import alu_pkg::*;
#(
  parameter int XLEN = ALU_XLEN
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      alu_op,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  logic signed [XLEN-1:0] a_s;
  logic signed [XLEN-1:0] b_s;

  assign a_s = $signed(a);
  assign b_s = $signed(b);

  always_comb begin
    result = a + b;
    case (alu_op)
      ALU_SUB: result = $unsigned(a_s - b_s);
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      default: result = $unsigned(a_s + b_s);
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/alu_exec_stage.sv
// Execute stage: ALU compute on the input side, registered into a main + skid
// pair at the EX/MEM boundary with a valid/ready handshake.
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int XLEN       = ALU_XLEN,
  parameter int REG_ADDR_W = ALU_REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            alu_op,
  input  logic                  alu_src,
  input  logic [XLEN-1:0]       rs1_data,
  input  logic [XLEN-1:0]       rs2_data,
  input  logic [XLEN-1:0]       imm,
  input  logic [XLEN-1:0]       pc,
  input  logic                  branch,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic                  reg_write,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       alu_result,
  output logic                  zero,
  output logic                  branch_taken,
  output logic [XLEN-1:0]       branch_target,
  output logic [XLEN-1:0]       store_data,
  output logic [REG_ADDR_W-1:0] rd_out,
  output logic                  reg_write_out,
  output logic                  mem_read_out,
  output logic                  mem_write_out
);

  logic [XLEN-1:0] op_b_p0;
  logic [XLEN-1:0] res_p0;
  logic            zero_p0;
  ex_mem_t         in_p0;
  ex_mem_t         main_p1;
  ex_mem_t         skid_p1;
  logic            vld_p1;
  logic            skid_vld_p1;
  logic            accept;
  logic            drain;

  // p0: operand select and compute on the incoming instruction
  assign op_b_p0 = alu_src ? imm : rs2_data;

  alu_core #(.XLEN(XLEN)) u_alu_core (
    .a      (rs1_data),
    .b      (op_b_p0),
    .alu_op (alu_op),
    .result (res_p0),
    .zero   (zero_p0)
  );

  assign in_p0 = '{
    alu_result:    res_p0,
    zero:          zero_p0,
    branch_taken:  branch & zero_p0,
    branch_target: pc + imm,
    store_data:    rs2_data,
    rd:            rd,
    reg_write:     reg_write,
    mem_read:      mem_read,
    mem_write:     mem_write
  };

  // Ready depends only on skid occupancy, so out_ready never reaches in_ready.
  assign in_ready = !skid_vld_p1;
  assign accept   = in_valid & in_ready;
  assign drain    = vld_p1 & out_ready;

  // p1: main register drives the outputs; skid absorbs one beat of stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
      main_p1     <= '0;
      skid_p1     <= '0;
    end else if (flush) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
    end else if (!vld_p1 || drain) begin
      if (skid_vld_p1) begin
        main_p1     <= skid_p1;
        vld_p1      <= 1'b1;
        skid_vld_p1 <= 1'b0;
      end else if (accept) begin
        main_p1 <= in_p0;
        vld_p1  <= 1'b1;
      end else begin
        vld_p1 <= 1'b0;
      end
    end else if (accept) begin
      skid_p1     <= in_p0;
      skid_vld_p1 <= 1'b1;
    end
  end

  assign out_valid     = vld_p1;
  assign alu_result    = main_p1.alu_result;
  assign zero          = main_p1.zero;
  assign branch_taken  = main_p1.branch_taken;
  assign branch_target = main_p1.branch_target;
  assign store_data    = main_p1.store_data;
  assign rd_out        = main_p1.rd;
  assign reg_write_out = main_p1.reg_write;
  assign mem_read_out  = main_p1.mem_read;
  assign mem_write_out = main_p1.mem_write;

  stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (vld_p1 && !out_ready) |=> $stable(main_p1));

  ready_means_skid_free: assert property (@(posedge clk) disable iff (!rst_n)
    !in_ready |-> skid_vld_p1);

endmodule

// File: tb/tb_alu_exec_stage.sv
// Scoreboard bench for alu_exec_stage: directed vectors push expected bundles,
// a negedge monitor pops and compares every drained output.
module tb_alu_exec_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  alu_op = '0;
  logic        alu_src = 1'b0;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic [31:0] imm = '0;
  logic [31:0] pc = '0;
  logic        branch = 1'b0;
  logic [4:0]  rd = '0;
  logic        reg_write = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] alu_result;
  logic        zero;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] store_data;
  logic [4:0]  rd_out;
  logic        reg_write_out;
  logic        mem_read_out;
  logic        mem_write_out;

  typedef struct packed {
    logic [31:0] res;
    logic        zero;
    logic        taken;
    logic [31:0] target;
    logic [31:0] store;
    logic [4:0]  rd;
    logic [2:0]  ctl;
  } exp_t;

  exp_t sb[$];
  exp_t mon_act;
  exp_t mon_exp;
  int   tests = 0;
  int   fails = 0;

  alu_exec_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .alu_src(alu_src), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .imm(imm), .pc(pc), .branch(branch), .rd(rd), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .alu_result(alu_result),
    .zero(zero), .branch_taken(branch_taken), .branch_target(branch_target),
    .store_data(store_data), .rd_out(rd_out), .reg_write_out(reg_write_out),
    .mem_read_out(mem_read_out), .mem_write_out(mem_write_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, need %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      mon_act = '{alu_result, zero, branch_taken, branch_target, store_data, rd_out,
                  {reg_write_out, mem_read_out, mem_write_out}};
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_out: got %h, need no output", mon_act);
      end else begin
        mon_exp = sb.pop_front();
        if (mon_act !== mon_exp) begin
          fails++;
          $display("FAIL bundle_rd%0d: got %h, need %h", mon_exp.rd, mon_act, mon_exp);
        end
      end
    end
  end

  task automatic send(input logic [3:0] op, input logic src, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] im, input logic [31:0] p,
                      input logic br, input logic [4:0] d, input logic [2:0] c,
                      input logic [31:0] er, input logic ez, input logic et,
                      input logic [31:0] etg, input bit keep);
    int n = 0;
    alu_op = op; alu_src = src; rs1_data = a; rs2_data = b; imm = im; pc = p;
    branch = br; rd = d; {reg_write, mem_read, mem_write} = c; in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL send_timeout_rd%0d: in_ready 0, need 1", d);
    end
    @(posedge clk);
    if (keep) sb.push_back('{er, ez, et, etg, b, d, c});
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  logic [3:0]  ops [6] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0011, 4'b1111};
  logic [31:0] exr [6] = '{32'h12, 32'h0C, 32'h03, 32'h0F, 32'h0C, 32'h12};

  initial begin
    // reset held with a valid input present
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {out_valid, alu_result, zero, branch_taken, branch_target,
          store_data, rd_out, reg_write_out, mem_read_out, mem_write_out}, '0);
    in_valid = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_reset", in_ready, 1);
    check("out_valid_after_reset", out_valid, 0);

    // every op, one cycle latency
    for (int i = 0; i < 6; i++) begin
      send(ops[i], 1'b0, 32'hF, 32'h3, 32'h10, 32'h1000, 1'b0, 5'(i + 1), 3'b100,
           exr[i], 1'b0, 1'b0, 32'h1010, 1'b1);
      in_valid = 1'b0;
      @(negedge clk);
      check("latency_one_cycle", out_valid, 1);
      @(posedge clk); #1;
    end

    // branch taken / not taken
    send(4'b0110, 1'b0, 32'h55, 32'h55, 32'h20, 32'h100, 1'b1, 5'd7, 3'b000,
         32'h0, 1'b1, 1'b1, 32'h120, 1'b1);
    send(4'b0110, 1'b0, 32'h56, 32'h55, 32'h20, 32'h100, 1'b1, 5'd8, 3'b000,
         32'h1, 1'b0, 1'b0, 32'h120, 1'b1);
    idle(2);

    // backpressure: two held, third waits, then all drain in order
    out_ready = 1'b0;
    send(4'b0010, 1'b0, 32'h1, 32'h2, 32'h0, 32'h0, 1'b0, 5'd11, 3'b100,
         32'h3, 1'b0, 1'b0, 32'h0, 1'b1);
    send(4'b0110, 1'b0, 32'h100, 32'h1, 32'h0, 32'h0, 1'b0, 5'd12, 3'b100,
         32'hFF, 1'b0, 1'b0, 32'h0, 1'b1);
    check("in_ready_skid_full", in_ready, 0);
    @(posedge clk); #1;
    check("out_valid_stalled", out_valid, 1);
    check("result_held_stalled", alu_result, 32'h3);
    out_ready = 1'b1;
    send(4'b0000, 1'b0, 32'hF0F0, 32'hFF00, 32'h0, 32'h0, 1'b0, 5'd13, 3'b010,
         32'hF000, 1'b0, 1'b0, 32'h0, 1'b1);
    send(4'b0001, 1'b0, 32'h0F, 32'hF0, 32'h0, 32'h0, 1'b0, 5'd14, 3'b001,
         32'hFF, 1'b0, 1'b0, 32'h0, 1'b1);
    send(4'b0011, 1'b0, 32'hAAAA, 32'hFFFF, 32'h0, 32'h0, 1'b0, 5'd15, 3'b110,
         32'h5555, 1'b0, 1'b0, 32'h0, 1'b1);
    idle(4);

    // flush with both entries held and another input offered
    out_ready = 1'b0;
    send(4'b0010, 1'b0, 32'h9, 32'h9, 32'h0, 32'h0, 1'b0, 5'd21, 3'b100, 0, 0, 0, 0, 1'b0);
    send(4'b0010, 1'b0, 32'hA, 32'hA, 32'h0, 32'h0, 1'b0, 5'd22, 3'b100, 0, 0, 0, 0, 1'b0);
    check("in_ready_before_flush", in_ready, 0);
    rd = 5'd23; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 1);
    // flush while an input is actually accepted
    send(4'b0010, 1'b0, 32'hB, 32'hB, 32'h0, 32'h0, 1'b0, 5'd24, 3'b100, 0, 0, 0, 0, 1'b0);
    rd = 5'd25; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_accept_out_valid", out_valid, 0);
    check("flush_accept_in_ready", in_ready, 1);
    out_ready = 1'b1;
    idle(4);

    // reset in the middle of a stall
    out_ready = 1'b0;
    send(4'b0010, 1'b0, 32'h7, 32'h7, 32'h0, 32'h0, 1'b0, 5'd26, 3'b100, 0, 0, 0, 0, 1'b0);
    send(4'b0010, 1'b0, 32'h8, 32'h8, 32'h0, 32'h0, 1'b0, 5'd27, 3'b100, 0, 0, 0, 0, 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midstall_reset_outputs", {out_valid, alu_result, zero, branch_taken, branch_target,
          store_data, rd_out, reg_write_out, mem_read_out, mem_write_out}, '0);
    check("midstall_reset_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    idle(3);
    check("after_reset_no_bundle", out_valid, 0);

    // wrap-around through the immediate operand
    send(4'b0010, 1'b1, 32'hFFFF_FFFF, 32'h1234, 32'h1, 32'h200, 1'b0, 5'd20, 3'b010,
         32'h0, 1'b1, 1'b0, 32'h201, 1'b1);
    idle(2);

    begin
      int n = 0;
      while (sb.size() != 0 && n < 100) begin
        @(posedge clk); #1; n++;
      end
    end
    check("scoreboard_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
